// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit owning the HI/LO registers.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract).
// Each takes WIDTH iterations plus one sign-fix cycle.
// MTHI/MTLO write HI/LO directly and pulse done the following cycle.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - issue request, sampled only while idle
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   a_in   - multiplicand / dividend / MTHI-MTLO source
//   b_in   - multiplier / divisor
//   busy   - high while an iterative op is in flight
//   done   - one-cycle pulse, HI/LO updated in the same cycle
//   hi     - HI register
//   lo     - LO register
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    // upper: product high half / partial remainder
    // lower: multiplier, shifted out / dividend, becoming the quotient
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] a_saved;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             div_zero;

    // Operand magnitudes and sign flags for the op presented at the port
    logic             signed_op_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;

    always_comb begin
        signed_op_c = (op == OP_MULT) || (op == OP_DIV);
        a_neg_c     = signed_op_c && a_in[WIDTH-1];
        b_neg_c     = signed_op_c && b_in[WIDTH-1];
        a_mag_c     = a_neg_c ? (~a_in + WIDTH'(1)) : a_in;
        b_mag_c     = b_neg_c ? (~b_in + WIDTH'(1)) : b_in;
    end

    // One multiply or divide iteration
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH:0]   rem_diff_c;
    logic [WIDTH-1:0] upper_next_c;
    logic [WIDTH-1:0] lower_next_c;

    always_comb begin
        mul_sum_c    = {1'b0, upper} + (lower[0] ? {1'b0, opnd_b} : (WIDTH + 1)'(0));
        rem_sh_c     = {upper, lower[WIDTH-1]};
        rem_diff_c   = rem_sh_c - {1'b0, opnd_b};
        upper_next_c = mul_sum_c[WIDTH:1];
        lower_next_c = {mul_sum_c[0], lower[WIDTH-1:1]};
        if (is_div) begin
            // No borrow out of the top bit means the divisor fits: keep the difference
            if (!rem_diff_c[WIDTH]) begin
                upper_next_c = rem_diff_c[WIDTH-1:0];
                lower_next_c = {lower[WIDTH-2:0], 1'b1};
            end else begin
                upper_next_c = rem_sh_c[WIDTH-1:0];
                lower_next_c = {lower[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final sign correction applied in the FIX cycle
    logic [2*WIDTH-1:0] prod_c;
    logic [2*WIDTH-1:0] prod_neg_c;
    logic [WIDTH-1:0]   fix_hi_c;
    logic [WIDTH-1:0]   fix_lo_c;

    always_comb begin
        prod_c     = {upper, lower};
        prod_neg_c = ~prod_c + (2 * WIDTH)'(1);
        {fix_hi_c, fix_lo_c} = neg_lo ? prod_neg_c : prod_c;
        if (is_div) begin
            if (div_zero) begin
                fix_hi_c = a_saved;
                fix_lo_c = '1;
            end else begin
                fix_lo_c = neg_lo ? (~lower + WIDTH'(1)) : lower;
                fix_hi_c = neg_hi ? (~upper + WIDTH'(1)) : upper;
            end
        end
    end

    // Control FSM, operand registers and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            upper    <= '0;
            lower    <= '0;
            opnd_b   <= '0;
            a_saved  <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                upper    <= '0;
                                lower    <= a_mag_c;
                                opnd_b   <= b_mag_c;
                                a_saved  <= a_in;
                                is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                                // Quotient and product share the sign rule; remainder follows the dividend
                                neg_lo   <= a_neg_c ^ b_neg_c;
                                neg_hi   <= a_neg_c;
                                div_zero <= (b_in == '0);
                                count    <= CNT_W'(WIDTH);
                                busy     <= 1'b1;
                                state    <= CALC;
                            end
                            OP_MTHI: begin
                                hi   <= a_in;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= a_in;
                                done <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                CALC: begin
                    upper <= upper_next_c;
                    lower <= lower_next_c;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= fix_hi_c;
                    lo    <= fix_lo_c;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed test of mul_div_unit against a cycle-level
// reference model (plain arithmetic plus a latency countdown), with
// hand-computed literal results for each directed operation.
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        op = 3'd0;
    logic [WIDTH-1:0]  a_in = '0;
    logic [WIDTH-1:0]  b_in = '0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Architectural result {hi, lo} of an iterative op
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = 64'(a);
        ub  = 64'(b);
        res = 64'd0;
        case (o)
            3'd0: res = 64'(sa * sb);
            3'd1: res = ua * ub;
            3'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Reference model: result lands WIDTH+1 edges after the accepting edge
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    logic        m_done = 1'b0;
    int          m_remain = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi     <= '0;
            m_lo     <= '0;
            m_done   <= 1'b0;
            m_remain <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_remain == 0) begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            {p_hi, p_lo} <= ref_result(op, a_in, b_in);
                            m_remain     <= WIDTH + 1;
                        end
                        3'd4: begin
                            m_hi   <= a_in;
                            m_done <= 1'b1;
                        end
                        3'd5: begin
                            m_lo   <= a_in;
                            m_done <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end else begin
                m_remain <= m_remain - 1;
                if (m_remain == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model; busy covers the CALC cycles only
    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_remain >= 2);
        n_cmp++;
        if ({hi, lo, busy, done} !== {m_hi, m_lo, m_busy, m_done}) begin
            n_bad++;
            $display("FAIL cycle@%0t: got hi=%h lo=%h busy=%b done=%b, expected hi=%h lo=%h busy=%b done=%b",
                     $time, hi, lo, busy, done, m_hi, m_lo, m_busy, m_done);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op, then check latency, busy cycles and final hi/lo; exp_lat < 0 means no done
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] eh, input logic [31:0] el, input string nm);
        int lat;
        int busy_cnt;
        int exp_busy;
        lat      = -1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k - 1;
                break;
            end
        end
        exp_busy = (exp_lat == WIDTH + 1) ? WIDTH : 0;
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dn;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset state", {hi, lo}, 64'd0);
        chk("reset busy/done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Model pins: literal expectations of the reference function
        chk("model MULT -3*7", ref_result(3'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model DIV minint/-1", ref_result(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, "MULTU max");
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7,         33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "MULT -3*7");
        run_op(3'd1, 32'hFFFF_FFFD, 32'd7,         33, 32'h0000_0006, 32'hFFFF_FFEB, "MULTU -3*7");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "DIV -7/2");
        run_op(3'd3, 32'd100,       32'd7,         33, 32'd2,         32'd14,        "DIVU 100/7");
        run_op(3'd3, 32'h1234_5678, 32'd0,         33, 32'h1234_5678, 32'hFFFF_FFFF, "DIVU by zero");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, "DIV minint/-1");
        run_op(3'd4, 32'hCAFE_BABE, 32'd0,         0,  32'hCAFE_BABE, 32'h8000_0000, "MTHI");
        run_op(3'd6, 32'h5555_5555, 32'd0,         -1, 32'hCAFE_BABE, 32'h8000_0000, "reserved op6");
        run_op(3'd5, 32'h0000_1234, 32'd0,         0,  32'hCAFE_BABE, 32'h0000_1234, "MTLO");

        // Restart ignored while busy, then reset aborts the op with no done
        dn = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        a_in  = 32'h1111_1111;
        b_in  = 32'h2222_2222;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 10) begin
                start = 1'b1;
                op    = 3'd3;
                a_in  = 32'd50;
                b_in  = 32'd5;
            end
            if (c == 11) start = 1'b0;
            if (done) dn++;
        end
        chk("busy before abort", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort clears hi/lo", {hi, lo}, 64'd0);
        chk("abort clears busy/done", {62'd0, busy, done}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            if (done) dn++;
        end
        #2 rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no done from aborted op", 64'(dn), 64'd0);

        run_op(3'd3, 32'd1000, 32'd33, 33, 32'd10, 32'd30, "DIVU after reset");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the Extended MIPS datapath. Owns the HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued by the core, using a start/busy/done handshake.
- Sits beside the single-cycle ALU. The core stalls on busy; MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand and HI/LO width. Also the iteration count.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request; sampled only when busy=0
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- a_in  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
- b_in  input  WIDTH  multiplier / divisor
- busy  output  1  high while an iterative op is in flight
- done  output  1  one-cycle pulse; HI/LO updated in the same cycle
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0, internal operands cleared. Reset mid-operation aborts immediately; no done is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 with op 0-3:
  - Latch operands. Signed ops latch magnitudes plus result-sign flags.
  - counter=WIDTH, busy=1 from the next cycle, go to CALC.
- IDLE, start=1 with op 4/5:
  - hi (MTHI) or lo (MTLO) <= a_in at that edge.
  - done=1 for the following cycle; busy stays 0.
- IDLE, start=1 with op 6/7: ignored. No state change, no done.
- start while busy=1 is ignored; operands are not re-sampled.
- CALC: one iteration per cycle, counter decrements; at counter==1 go to FIX.
  - Multiply: shift-add on {acc, multiplier}, 2*WIDTH-bit product.
  - Divide: restoring shift-subtract on {rem, quotient}.
- FIX (one cycle):
  - Apply two's-complement sign correction.
  - Write hi/lo, assert done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
- Latency: start sampled at edge E0 → hi/lo written and done high after edge E0+WIDTH+1. That is 33 cycles for WIDTH=32. busy is high for cycles E0+1 .. E0+WIDTH.
- A new start may be presented in the done cycle; it is accepted because busy=0.
- Multiply results:
  - hi = product[2W-1:W], lo = product[W-1:0].
  - MULT: product is negated when the operand signs differ.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / -1 (signed) gives lo=0x80000000, hi=0. This is the natural wrap; no trap.
- Divide by zero (DIV or DIVU):
  - lo=all ones, hi=a_in as latched at start; sign correction is skipped.
  - Latency is unchanged.
- hi/lo hold their values at all times except at a write edge.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001. busy high for exactly 32 cycles.
2. MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU on the same operands → hi=0x00000006, lo=0xFFFFFFEB.
3. DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 → lo=14, hi=2.
4. DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
5. MTHI a=0xCAFEBABE → hi updated at the next edge, done pulses 1 cycle, busy stays 0, lo unchanged. Reserved op 6 → no done, hi/lo unchanged.
6. Start MULTU, pulse start again with new operands at cycle 10, then assert rst_n=0 at cycle 20 → second start ignored; reset clears hi/lo/busy immediately; no done is ever seen. A fresh DIVU after reset completes correctly.
